diod_sweep_ctrl: RTL and testbench
==================================

Name: diod_sweep_ctrl

Overview:
Multi-channel successor of the single-diode controller. Ramps a DAC voltage per channel over SPI, dwells at each step, and watches that channel's debounced noise_valid line. The first voltage that produces noise is recorded as that channel's threshold, then the sweep moves to the next channel. Sits between the top-level start/noise inputs and the external multi-channel SPI DAC; results feed the storage block via store_en.

Parameters:
CH_NUM, 4, number of diode channels (1..16)
DAC_W, 8, DAC code width in bits
V_STEP, 1, ramp increment in DAC codes (1..2^DAC_W-1)
DWELL_CYC, 1000, clk cycles waited after each SPI frame before sampling (>=DEBOUNCE)
SPI_DIV, 4, spi_clk half-period in clk cycles (>=1)
DEBOUNCE, 4, consecutive high samples required to declare a hit (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that starts a sweep of all channels; ignored while busy
abort  in  1  level; cancels the sweep
noise_valid  in  CH_NUM  asynchronous per-channel noise detect
spi_mosi  out  1  SPI data, MSB first
spi_clk  out  1  SPI clock, mode 0 (idle low)
spi_ss  out  1  SPI chip select, active low
busy  out  1  high from start accept until done or abort
done  out  1  one-cycle pulse when the sweep completes normally
store_en  out  1  one-cycle pulse: result_* valid
result_ch  out  clog2(CH_NUM) max 1  channel index of the result
result_voltage  out  DAC_W  threshold code, or max code on miss
result_hit  out  1  1 = noise found, 0 = ramp exhausted
debug_voltage  out  DAC_W  current DAC code
spi_start  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (reset=0, async) drives all outputs low except spi_ss=1, and puts the FSM in IDLE.
- States: IDLE -> LOAD -> SPI_TX -> DWELL -> CHECK -> (STORE | LOAD) ... -> DONE -> IDLE.
- IDLE: a start pulse clears ch=0 and voltage=0, sets busy, and goes to LOAD.
- LOAD: builds the frame {ch zero-extended to 4 bits, voltage}, FRAME_W = 4+DAC_W. Pulses spi_start and goes to SPI_TX.
- SPI_TX:
  - spi_ss falls in the first SPI_TX cycle; MOSI is presented one half-period before each rising edge.
  - spi_clk toggles every SPI_DIV cycles for FRAME_W full periods.
  - spi_ss rises one half-period after the last falling edge.
  - Frame length is FRAME_W*2*SPI_DIV + SPI_DIV cycles.
- DWELL: counts DWELL_CYC cycles.
  - noise_valid[ch] passes through a 2-flop synchroniser.
  - The run counter increments while the synced input is high, clears on low, and saturates at DEBOUNCE.
  - The hit flag is sticky within the dwell; both the counter and the flag clear on DWELL entry.
- CHECK:
  - If hit, go to STORE with hit=1 and the current voltage.
  - Else, if voltage == 2^DAC_W-1, go to STORE with hit=0.
  - Else: voltage += V_STEP, clamped to 2^DAC_W-1 if the sum overflows; go to LOAD.
- STORE: pulses store_en for one cycle with result_* held stable. Then:
  - If ch == CH_NUM-1, go to DONE.
  - Else ch++, voltage=0, go to LOAD.
- DONE: pulses done, clears busy, returns to IDLE.
- Abort in any non-IDLE state:
  - next cycle spi_ss=1, spi_clk=0, busy=0, state IDLE;
  - no store_en or done is issued; a partial frame is discarded by the SS rise.
- Start during busy is ignored. Start and abort in the same IDLE cycle: abort wins.
- A noise pulse outside DWELL is ignored.
- debug_voltage always equals the registered voltage.

Optional Feature:
DIOD_PARK_EN
- Defined: after each STORE, the FSM sends one extra frame {ch, 0} (PARK state reusing SPI_TX) before advancing, so every diode returns to 0 V after measurement. No dwell follows the park frame.
- Undefined: the DAC keeps its last code; PARK state is absent.

Decomposition:
- Package diod_pkg: state enum typedef, ADDR_PAD_W=4 constant, and a frame-width function.
- Sub-module diod_spi_tx (FRAME_W, SPI_DIV): load/start in, busy/done out, drives mosi/clk/ss. The FSM, debouncer and ramp stay in the top.

Test Plan:
Bench parameters: CH_NUM=2, DAC_W=8, V_STEP=16, DWELL_CYC=20, SPI_DIV=2, DEBOUNCE=3.
1. Reset then idle, no start -> spi_ss=1, spi_clk=0, busy=0, debug_voltage=0, no store_en.
2. start, noise_valid held 0 -> each channel ramps 0,16,...,240,255. store_en fires twice with hit=0, voltage=0xFF, ch 0 then 1; then done pulses once.
3. noise_valid[0] high from the dwell at code 0x30 -> store ch0 voltage=0x30 hit=1. Frames decoded on posedge spi_clk read 0x030 for ch0 and 0x100 for ch1's first frame.
4. noise_valid[1] high for 2 cycles in every dwell -> no hit (below DEBOUNCE); ch1 result is 0xFF, hit=0.
5. abort asserted mid-frame on ch1 -> spi_ss=1 next cycle, busy=0, no done; a following start resweeps from ch0 voltage 0.
6. With DIOD_PARK_EN -> after each store_en, a frame {ch,0x00} appears before the next channel's first frame.

Source files
------------

// File: rtl/diod_pkg.sv
// Shared types and helpers for the diode sweep controller.
// DIOD_PARK_EN adds the PARK state that returns each DAC channel to 0.
package diod_pkg;

  localparam int ADDR_PAD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SPI_TX,
    ST_DWELL,
    ST_CHECK,
    ST_STORE,
`ifdef DIOD_PARK_EN
    ST_PARK,
`endif
    ST_DONE
  } state_t;

  function automatic int frame_w(input int dac_w);
    return ADDR_PAD_W + dac_w;
  endfunction

endpackage

// File: rtl/diod_sweep_ctrl_if.sv
// Control, noise, SPI and result bundle of the diode sweep controller.
// master = controller side, slave = environment side.
interface diod_sweep_ctrl_if #(
  parameter int CH_NUM = 4,
  parameter int DAC_W  = 8
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic              start;
  logic              abort;
  logic [CH_NUM-1:0] noise_valid;
  logic              spi_mosi;
  logic              spi_clk;
  logic              spi_ss;
  logic              busy;
  logic              done;
  logic              store_en;
  logic [CH_W-1:0]   result_ch;
  logic [DAC_W-1:0]  result_voltage;
  logic              result_hit;
  logic [DAC_W-1:0]  debug_voltage;
  logic              spi_start;

  modport master (
    input  start, abort, noise_valid,
    output spi_mosi, spi_clk, spi_ss,
    output busy, done, store_en,
    output result_ch, result_voltage, result_hit,
    output debug_voltage, spi_start
  );

  modport slave (
    output start, abort, noise_valid,
    input  spi_mosi, spi_clk, spi_ss,
    input  busy, done, store_en,
    input  result_ch, result_voltage, result_hit,
    input  debug_voltage, spi_start
  );
endinterface

// File: rtl/diod_spi_tx.sv
// Mode-0 SPI frame shifter, MSB first, with SS held one half-period
// past the last falling edge.
module diod_spi_tx #(
  parameter int FRAME_W = 12,
  parameter int SPI_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               mosi,
  output logic               sclk,
  output logic               ss
);
  localparam int EDGES  = 2 * FRAME_W;
  localparam int DIV_W  = $clog2(SPI_DIV + 1);
  localparam int EDGE_W = $clog2(EDGES + 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               tick;

  assign tick = busy && (div_cnt == DIV_W'(SPI_DIV - 1));
  assign done = tick && (edge_cnt == EDGE_W'(EDGES));
  assign mosi = shreg[FRAME_W-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shreg    <= '0;
    end else if (abort) begin
      busy     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shreg    <= '0;
    end else if (load) begin
      busy     <= 1'b1;
      ss       <= 1'b0;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shreg    <= frame;
    end else if (busy) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        ss   <= 1'b1;
      end else if (tick) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        // next bit goes out on the falling edge
        if (sclk) shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/diod_sweep_ctrl.sv
// Multi-channel diode threshold sweep: ramps each DAC channel over SPI,
// dwells, debounces noise_valid. Optional DIOD_PARK_EN parks each channel at 0.
module diod_sweep_ctrl
  import diod_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int DAC_W     = 8,
  parameter int V_STEP    = 1,
  parameter int DWELL_CYC = 1000,
  parameter int SPI_DIV   = 4,
  parameter int DEBOUNCE  = 4
) (
  input logic                clk,
  input logic                reset,
  diod_sweep_ctrl_if.master  bus
);
  localparam int FRAME_W = frame_w(DAC_W);
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DW_W    = $clog2(DWELL_CYC + 1);
  localparam int RUN_W   = $clog2(DEBOUNCE + 1);
  localparam logic [DAC_W-1:0] V_MAX = '1;

  state_t             state, state_nxt;
  logic [CH_W-1:0]    ch;
  logic [DAC_W-1:0]   voltage;
  logic [CH_NUM-1:0]  sync1, sync2;
  logic [DW_W-1:0]    dwell_cnt;
  logic [RUN_W-1:0]   run_cnt;
  logic               hit;
  logic               parking;
  logic               tx_load, tx_busy, tx_done;
  logic [FRAME_W-1:0] tx_frame;
  logic               abort_go, go, last_ch;
  logic               dwell_end, noise_s, at_end;
  logic [DAC_W:0]     v_sum;

  assign abort_go  = bus.abort && (state != ST_IDLE);
  assign go        = bus.start && !bus.abort;
  assign last_ch   = ch == CH_W'(CH_NUM - 1);
  assign dwell_end = dwell_cnt == DW_W'(DWELL_CYC - 1);
  assign noise_s   = sync2[ch];
  assign at_end    = hit || (voltage == V_MAX);
  assign v_sum     = {1'b0, voltage} + (DAC_W + 1)'(V_STEP);

  assign bus.busy          = state != ST_IDLE;
  assign bus.done          = state == ST_DONE;
  assign bus.store_en      = state == ST_STORE;
  assign bus.debug_voltage = voltage;
`ifdef DIOD_PARK_EN
  assign bus.spi_start = (state == ST_LOAD) || (state == ST_PARK);
`else
  assign bus.spi_start = state == ST_LOAD;
`endif

  diod_spi_tx #(
    .FRAME_W (FRAME_W),
    .SPI_DIV (SPI_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .abort (abort_go),
    .frame (tx_frame),
    .busy  (tx_busy),
    .done  (tx_done),
    .mosi  (bus.spi_mosi),
    .sclk  (bus.spi_clk),
    .ss    (bus.spi_ss)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_frame  = {ADDR_PAD_W'(ch), voltage};
    unique case (state)
      ST_IDLE:  if (go) state_nxt = ST_LOAD;
      ST_LOAD: begin
        tx_load   = 1'b1;
        state_nxt = ST_SPI_TX;
      end
      ST_SPI_TX: begin
        if (tx_done) begin
          if (!parking)     state_nxt = ST_DWELL;
          else if (last_ch) state_nxt = ST_DONE;
          else              state_nxt = ST_LOAD;
        end else if (!tx_busy) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DWELL: if (dwell_end) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = at_end ? ST_STORE : ST_LOAD;
`ifdef DIOD_PARK_EN
      ST_STORE: state_nxt = ST_PARK;
      ST_PARK: begin
        tx_load   = 1'b1;
        tx_frame  = {ADDR_PAD_W'(ch), {DAC_W{1'b0}}};
        state_nxt = ST_SPI_TX;
      end
`else
      ST_STORE: state_nxt = last_ch ? ST_DONE : ST_LOAD;
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_go) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch                 <= '0;
      voltage            <= '0;
      sync1              <= '0;
      sync2              <= '0;
      dwell_cnt          <= '0;
      run_cnt            <= '0;
      hit                <= 1'b0;
      parking            <= 1'b0;
      bus.result_ch      <= '0;
      bus.result_voltage <= '0;
      bus.result_hit     <= 1'b0;
    end else begin
      sync1 <= bus.noise_valid;
      sync2 <= sync1;
      if (abort_go) begin
        parking <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (go) begin
            ch      <= '0;
            voltage <= '0;
            parking <= 1'b0;
          end
          ST_SPI_TX: if (tx_done) begin
            dwell_cnt <= '0;
            run_cnt   <= '0;
            hit       <= 1'b0;
            parking   <= 1'b0;
            if (parking && !last_ch) begin
              ch      <= ch + 1'b1;
              voltage <= '0;
            end
          end
          ST_DWELL: begin
            dwell_cnt <= dwell_cnt + 1'b1;
            if (!noise_s)
              run_cnt <= '0;
            else if (run_cnt != RUN_W'(DEBOUNCE))
              run_cnt <= run_cnt + 1'b1;
            if (noise_s && run_cnt >= RUN_W'(DEBOUNCE - 1))
              hit <= 1'b1;
          end
          ST_CHECK: begin
            if (at_end) begin
              bus.result_ch      <= ch;
              bus.result_voltage <= voltage;
              bus.result_hit     <= hit;
            end else begin
              voltage <= v_sum[DAC_W] ? V_MAX : v_sum[DAC_W-1:0];
            end
          end
`ifdef DIOD_PARK_EN
          ST_STORE: parking <= 1'b1;
`else
          ST_STORE: if (!last_ch) begin
            ch      <= ch + 1'b1;
            voltage <= '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diod_sweep_ctrl.sv
// Bench for diod_sweep_ctrl: threshold vectors checked against a ramp
// model, plus reset, abort, short-pulse and start/abort corner sequences.
module tb_diod_sweep_ctrl;

  localparam int CH_NUM = 2;
  localparam int DAC_W  = 8;
  localparam int FLEN   = (2 * 12 + 1) * 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  diod_sweep_ctrl_if #(.CH_NUM(CH_NUM), .DAC_W(DAC_W)) bus ();

  diod_sweep_ctrl #(
    .CH_NUM    (CH_NUM),
    .DAC_W     (DAC_W),
    .V_STEP    (16),
    .DWELL_CYC (20),
    .SPI_DIV   (2),
    .DEBOUNCE  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [1:0][8:0] thr;
    logic [1:0][7:0] ev;
    logic [1:0]      eh;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  thr [2];
  bit          pulse_mode = 1'b0;
  int          sweep_id = 0;
  int          seen_id = 0;
  int          since_fall = 0, since_rise = 0;
  int          bits = 0, len = 0, len_bad = 0;
  int          done_cnt = 0, start_cnt = 0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0;
  logic [11:0] sh = '0;
  logic [1:0]  nz = '0, pv = '0;
  logic [11:0] frames [$];
  logic [9:0]  stores [$];
  logic [11:0] exp_q [$];

  // Monitor: decodes SPI frames and drives noise from the decoded DAC codes
  always @(negedge clk) begin
    if (seen_id != sweep_id) begin
      seen_id = sweep_id;
      frames.delete();
      stores.delete();
      nz = '0;
      len_bad = 0;
      done_cnt = 0;
      start_cnt = 0;
    end
    if (bus.store_en)
      stores.push_back({bus.result_ch, bus.result_voltage, bus.result_hit});
    if (bus.done) done_cnt++;
    if (bus.spi_start) start_cnt++;
    if (!bus.spi_ss) begin
      if (prev_ss) begin
        bits = 0;
        len = 0;
        since_fall = 0;
      end
      len++;
      since_fall++;
      if (bus.spi_clk && !prev_sclk) begin
        sh = {sh[10:0], bus.spi_mosi};
        bits++;
      end
    end else begin
      if (!prev_ss) begin
        since_rise = 0;
        if (bits == 12) begin
          frames.push_back(sh);
          if (len != FLEN) len_bad++;
          if ({1'b0, sh[7:0]} >= thr[sh[8]]) nz[sh[8]] = 1'b1;
        end
      end
      since_rise++;
    end
    prev_ss = bus.spi_ss;
    prev_sclk = bus.spi_clk;
    pv[0] = pulse_mode && !bus.spi_ss && since_fall >= 5 && since_fall <= 30;
    pv[1] = pulse_mode && bus.spi_ss && since_rise >= 5 && since_rise <= 6;
    bus.noise_valid = nz | pv;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int next_code(input int x);
    return (x + 16 > 255) ? 255 : x + 16;
  endfunction

  // First ramp code at or above the threshold, or a miss at full scale
  task automatic ref_ch(input logic [8:0] t, output logic [7:0] v,
                        output logic h);
    int x;
    x = 0;
    v = 8'hFF;
    h = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (x >= int'(t)) begin
        v = 8'(x);
        h = 1'b1;
        break;
      end
      if (x == 255) break;
      x = next_code(x);
    end
  endtask

  task automatic build_exp(input logic [8:0] t0, input logic [8:0] t1);
    logic [8:0] t;
    int x;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      t = (c == 0) ? t0 : t1;
      x = 0;
      for (int k = 0; k < 40; k++) begin
        exp_q.push_back({4'(c), 8'(x)});
        if (x >= int'(t) || x == 255) break;
        x = next_code(x);
      end
`ifdef DIOD_PARK_EN
      exp_q.push_back({4'(c), 8'h00});
`endif
    end
  endtask

  task automatic start_sweep(input logic [8:0] t0, input logic [8:0] t1);
    thr[0] = t0;
    thr[1] = t1;
    @(negedge clk);
    sweep_id++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_on", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input bit poke);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 8000) begin
      @(negedge clk);
      n++;
      if (poke && n == 300) bus.start = 1'b1;
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("sweep_timeout", 32'(n >= 8000), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_sweep(input vec_t v);
    int bad;
    logic [9:0] got;
    check("store_cnt", 32'(stores.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      got = (i < stores.size()) ? stores[i] : 10'h3FF;
      check("store", 32'(got), 32'({i[0], v.ev[i], v.eh[i]}));
    end
    check("done_cnt", 32'(done_cnt), 32'd1);
    build_exp(v.thr[0], v.thr[1]);
    check("frame_cnt", 32'(frames.size()), 32'(exp_q.size()));
    bad = 0;
    for (int k = 0; k < exp_q.size() && k < frames.size(); k++)
      if (frames[k] !== exp_q[k]) bad++;
    check("frame_data", 32'(bad), 32'd0);
    check("frame_len", 32'(len_bad), 32'd0);
    check("spi_start_cnt", 32'(start_cnt), 32'(exp_q.size()));
    check("busy_off", 32'({bus.busy, bus.spi_ss}), 32'b01);
  endtask

  vec_t vt [8];
  vec_t pv_vec;

  initial begin
    int n, n0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.noise_valid = '0;
    thr[0] = 9'h100;
    thr[1] = 9'h100;

    vt[0] = '{thr: {9'h100, 9'h030}, ev: {8'hFF, 8'h30}, eh: 2'b01};
    vt[1] = '{thr: {9'h100, 9'h100}, ev: {8'hFF, 8'hFF}, eh: 2'b00};
    vt[2] = '{thr: {9'h000, 9'h000}, ev: {8'h00, 8'h00}, eh: 2'b11};
    vt[3] = '{thr: {9'h0F1, 9'h031}, ev: {8'hFF, 8'h40}, eh: 2'b11};
    vt[4] = '{thr: {9'h0FF, 9'h0F0}, ev: {8'hFF, 8'hF0}, eh: 2'b11};
    for (int i = 5; i < 8; i++) begin
      for (int c = 0; c < 2; c++) begin
        n = int'($urandom_range(0, 300));
        vt[i].thr[c] = (n > 256) ? 9'h100 : 9'(n);
        ref_ch(vt[i].thr[c], vt[i].ev[c], vt[i].eh[c]);
      end
    end

    repeat (3) @(negedge clk);
    check("reset_out",
          32'({bus.spi_ss, bus.spi_clk, bus.spi_mosi, bus.busy,
               bus.done, bus.store_en, bus.spi_start, bus.result_hit}),
          32'b1000_0000);
    check("reset_data",
          32'({bus.debug_voltage, bus.result_voltage, bus.result_ch}), 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_out",
          32'({bus.spi_ss, bus.spi_clk, bus.busy, bus.debug_voltage}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    check("idle_quiet", 32'(stores.size() + start_cnt + done_cnt), 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 32'd0);
    repeat (30) @(negedge clk);
    check("start_abort_quiet", 32'(start_cnt + frames.size()), 0);

    for (int i = 0; i < 8; i++) begin
      start_sweep(vt[i].thr[0], vt[i].thr[1]);
      wait_done(i == 1);
      check_sweep(vt[i]);
    end

    // short ch1 pulses in dwell and long ch0 pulses during frames only
    pv_vec = '{thr: {9'h100, 9'h100}, ev: {8'hFF, 8'hFF}, eh: 2'b00};
    pulse_mode = 1'b1;
    start_sweep(pv_vec.thr[0], pv_vec.thr[1]);
    wait_done(1'b0);
    check_sweep(pv_vec);
    pulse_mode = 1'b0;

    // abort in the middle of ch1's first frame
`ifdef DIOD_PARK_EN
    n0 = 18;
`else
    n0 = 17;
`endif
    start_sweep(9'h100, 9'h100);
    n = 0;
    while (frames.size() < n0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (bus.spi_ss && n < 5200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", 32'(n >= 5000), 32'd0);
    repeat (15) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_out", 32'({bus.spi_ss, bus.spi_clk, bus.busy}), 32'b100);
    repeat (200) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_stores", 32'(stores.size()), 32'd1);
    check("abort_idle", 32'({bus.spi_ss, bus.busy}), 32'b10);

    start_sweep(vt[0].thr[0], vt[0].thr[1]);
    wait_done(1'b0);
    check_sweep(vt[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
